// File: rtl/axis_fir_pkg.sv
// Shared types and helpers for the programmable AXI-Stream FIR filter.
package axis_fir_pkg;

   // Packet-level control state of the filter.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fir_state_e;

   // Result selection when the accumulator is narrowed to the output width.
   typedef enum logic [1:0] {
      SEL_PASS = 2'd0,
      SEL_MAX  = 2'd1,
      SEL_MIN  = 2'd2
   } narrow_sel_e;

   // Input handshake to output valid, in clock cycles, with no stall.
   localparam int LATENCY = 3;

   // Full-precision accumulator width for a given filter geometry.
   function automatic int acc_width(input int din_w, input int tap_w, input int num_taps);
      return din_w + tap_w + $clog2(num_taps);
   endfunction

   // Coefficient address width, never narrower than one bit.
   function automatic int addr_width(input int num_taps);
      return (num_taps > 1) ? $clog2(num_taps) : 1;
   endfunction

   // Decide how an accumulator value maps onto the narrower output:
   // pass the low bits when it fits (or wrapping is wanted), else clamp by sign.
   function automatic narrow_sel_e narrow_select(input logic fits, input logic neg, input logic sat_en);
      narrow_sel_e sel;
      if (fits || !sat_en) begin
         sel = SEL_PASS;
      end else if (neg) begin
         sel = SEL_MIN;
      end else begin
         sel = SEL_MAX;
      end
      return sel;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// One-entry output skid buffer carrying data and tlast. While it holds a
// beat the upstream pipeline is frozen (full is high).
module axis_skid_buffer
#(
   parameter int DATA_W = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              full
);

   logic              full_r;
   logic [DATA_W-1:0] data_r;
   logic              last_r;

   // Capture a stalled beat when empty; release it once downstream is ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_r <= 1'b0;
         data_r <= '0;
         last_r <= 1'b0;
      end else if (full_r) begin
         if (out_ready) begin
            full_r <= 1'b0;
         end
      end else if (in_valid && !out_ready) begin
         full_r <= 1'b1;
         data_r <= in_data;
         last_r <= in_last;
      end
   end

   assign out_valid = full_r || in_valid;
   assign out_data  = full_r ? data_r : in_data;
   assign out_last  = full_r ? last_r : in_last;
   assign full      = full_r;

endmodule

// File: rtl/axis_fir_filter_prog.sv
// Programmable direct-form FIR filter with AXI-Stream input/output.
// Three register stages: delay line, per-tap products, accumulated sum.
// A one-entry skid buffer on the output freezes the pipeline on backpressure.
module axis_fir_filter_prog
   import axis_fir_pkg::*;
#(
   parameter int NUM_TAPS       = 4,
   parameter int TAP_WIDTH      = 8,
   parameter int DATA_IN_WIDTH  = 8,
   parameter int DATA_OUT_WIDTH = 18,
   parameter int SATURATE       = 1
)
(
   input  logic                                clk,
   input  logic                                rst,
   input  logic signed [DATA_IN_WIDTH-1:0]     s_axis_tdata,
   input  logic                                s_axis_tvalid,
   input  logic                                s_axis_tlast,
   output logic                                s_axis_tready,
   output logic signed [DATA_OUT_WIDTH-1:0]    m_axis_tdata,
   output logic                                m_axis_tvalid,
   output logic                                m_axis_tlast,
   input  logic                                m_axis_tready,
   input  logic                                coef_wr_en,
   input  logic [addr_width(NUM_TAPS)-1:0]     coef_addr,
   input  logic signed [TAP_WIDTH-1:0]         coef_wdata,
   output logic                                busy
);

   localparam int ACC_WIDTH = acc_width(DATA_IN_WIDTH, TAP_WIDTH, NUM_TAPS);
   localparam int PROD_W    = DATA_IN_WIDTH + TAP_WIDTH;

   fir_state_e                  state_r;
   fir_state_e                  state_nxt_s;
   logic                        advance_s;
   logic                        in_hs_s;
   logic                        out_hs_s;
   logic                        coef_we_s;
   logic                        clear_dl_s;
   logic                        skid_full_s;

   logic signed [TAP_WIDTH-1:0]     h_r    [NUM_TAPS];
   logic signed [DATA_IN_WIDTH-1:0] dl_r   [NUM_TAPS];
   logic signed [PROD_W-1:0]        prod_r [NUM_TAPS];
   logic signed [ACC_WIDTH-1:0]     sum_s;
   logic signed [ACC_WIDTH-1:0]     acc3_r;
   logic [DATA_OUT_WIDTH-1:0]       narrow_s;
   logic                            valid1_r, last1_r;
   logic                            valid2_r, last2_r;
   logic                            valid3_r, last3_r;

   // The whole pipeline holds while the skid buffer is occupied.
   assign advance_s     = !skid_full_s;
   assign s_axis_tready = !skid_full_s && (state_r != ST_DRAIN);
   assign in_hs_s       = s_axis_tvalid && s_axis_tready;
   assign out_hs_s      = m_axis_tvalid && m_axis_tready;
   assign busy          = (state_r != ST_IDLE);
   assign coef_we_s     = coef_wr_en && !busy && !in_hs_s;
   assign clear_dl_s    = (state_nxt_s == ST_IDLE) && (state_r != ST_IDLE);

   // Packet state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Packet state transitions: a tlast input closes intake until its output leaves.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (in_hs_s) begin
               state_nxt_s = s_axis_tlast ? ST_DRAIN : ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (in_hs_s && s_axis_tlast) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (out_hs_s && m_axis_tlast) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Coefficient bank: identity after reset, writable only between packets.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            h_r[k] <= '0;
         end
         h_r[0] <= TAP_WIDTH'(1'b1);
      end else begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            if (coef_we_s && (int'(coef_addr) == k)) begin
               h_r[k] <= coef_wdata;
            end
         end
      end
   end

   // Stage 1: delay line shifts on each accepted sample, cleared between packets.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            dl_r[k] <= '0;
         end
      end else if (clear_dl_s) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            dl_r[k] <= '0;
         end
      end else if (in_hs_s) begin
         dl_r[0] <= s_axis_tdata;
         for (int k = 1; k < NUM_TAPS; k++) begin
            dl_r[k] <= dl_r[k-1];
         end
      end
   end

   // Stage 1..3 valid/last, stage 2 products and stage 3 sum; all hold on stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid1_r <= 1'b0;
         last1_r  <= 1'b0;
         valid2_r <= 1'b0;
         last2_r  <= 1'b0;
         valid3_r <= 1'b0;
         last3_r  <= 1'b0;
         acc3_r   <= '0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            prod_r[k] <= '0;
         end
      end else if (advance_s) begin
         valid1_r <= in_hs_s;
         last1_r  <= in_hs_s && s_axis_tlast;
         valid2_r <= valid1_r;
         last2_r  <= last1_r;
         valid3_r <= valid2_r;
         last3_r  <= last2_r;
         acc3_r   <= sum_s;
         for (int k = 0; k < NUM_TAPS; k++) begin
            prod_r[k] <= PROD_W'(dl_r[k]) * PROD_W'(h_r[k]);
         end
      end
   end

   // Full-precision adder tree over the registered products.
   always_comb begin
      sum_s = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         sum_s = sum_s + ACC_WIDTH'(prod_r[k]);
      end
   end

   generate
      if (DATA_OUT_WIDTH >= ACC_WIDTH) begin : g_extend
         // Output is at least as wide as the accumulator: sign-extend.
         always_comb begin
            narrow_s = DATA_OUT_WIDTH'(acc3_r);
         end
      end else begin : g_narrow
         logic [ACC_WIDTH-DATA_OUT_WIDTH:0] upper_s;
         logic                              fits_s;
         narrow_sel_e                       sel_s;

         // Value fits when all bits from the output sign bit upward agree.
         always_comb begin
            upper_s = acc3_r[ACC_WIDTH-1:DATA_OUT_WIDTH-1];
            fits_s  = (&upper_s) || !(|upper_s);
            sel_s   = narrow_select(fits_s, acc3_r[ACC_WIDTH-1], SATURATE != 0);
            case (sel_s)
               SEL_MAX:  narrow_s = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
               SEL_MIN:  narrow_s = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};
               SEL_PASS: narrow_s = acc3_r[DATA_OUT_WIDTH-1:0];
               default:  narrow_s = acc3_r[DATA_OUT_WIDTH-1:0];
            endcase
         end
      end
   endgenerate

   axis_skid_buffer #(
      .DATA_W (DATA_OUT_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (valid3_r),
      .in_data   (narrow_s),
      .in_last   (last3_r),
      .out_ready (m_axis_tready),
      .out_valid (m_axis_tvalid),
      .out_data  (m_axis_tdata),
      .out_last  (m_axis_tlast),
      .full      (skid_full_s)
   );

endmodule

// File: tb/tb_axis_fir_filter_prog.sv
// Scoreboard bench for axis_fir_filter_prog: a plain-arithmetic FIR model
// predicts each output when its input is accepted; a monitor pops and compares.
module tb_axis_fir_filter_prog;
   import axis_fir_pkg::*;

   localparam int NT = 4;

   typedef struct {
      int data;
      bit last;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   logic signed [7:0]  s_data;
   logic               s_valid, s_last, s_ready;
   logic signed [17:0] m_data;
   logic               m_valid, m_last, m_ready;
   logic               coef_we;
   logic [1:0]         coef_addr;
   logic signed [7:0]  coef_wdata;
   logic               busy;

   logic signed [7:0]  q_data;
   logic               q_valid, q_last;
   logic               q_we;
   logic [1:0]         q_addr;
   logic signed [7:0]  q_wdata;
   logic               one_r;
   logic signed [7:0]  sat_m_data, wrap_m_data;
   logic               sat_s_ready, sat_m_valid, sat_m_last, sat_busy;
   logic               wrap_s_ready, wrap_m_valid, wrap_m_last, wrap_busy;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   bp_mode  = 0;
   exp_t exp_q[$];
   int   hist[$];
   int   model_h[NT];
   bit   hold_v = 1'b0;
   int   hold_d;
   bit   hold_l;

   axis_fir_filter_prog u_dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(s_ready),
      .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last), .m_axis_tready(m_ready),
      .coef_wr_en(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy)
   );

   axis_fir_filter_prog #(.DATA_OUT_WIDTH(8), .SATURATE(1)) u_sat (
      .clk(clk), .rst(rst),
      .s_axis_tdata(q_data), .s_axis_tvalid(q_valid), .s_axis_tlast(q_last), .s_axis_tready(sat_s_ready),
      .m_axis_tdata(sat_m_data), .m_axis_tvalid(sat_m_valid), .m_axis_tlast(sat_m_last), .m_axis_tready(one_r),
      .coef_wr_en(q_we), .coef_addr(q_addr), .coef_wdata(q_wdata), .busy(sat_busy)
   );

   axis_fir_filter_prog #(.DATA_OUT_WIDTH(8), .SATURATE(0)) u_wrap (
      .clk(clk), .rst(rst),
      .s_axis_tdata(q_data), .s_axis_tvalid(q_valid), .s_axis_tlast(q_last), .s_axis_tready(wrap_s_ready),
      .m_axis_tdata(wrap_m_data), .m_axis_tvalid(wrap_m_valid), .m_axis_tlast(wrap_m_last), .m_axis_tready(one_r),
      .coef_wr_en(q_we), .coef_addr(q_addr), .coef_wdata(q_wdata), .busy(wrap_busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: y[n] = sum_k h[k]*x[n-k] over this packet's samples only.
   task automatic model_accept(input int x, input bit last, input bit lat);
      int y;
      exp_t e;
      hist.push_front(x);
      y = 0;
      for (int k = 0; k < NT; k++) begin
         if (k < hist.size()) y += model_h[k] * hist[k];
      end
      e.data = y;
      e.last = last;
      e.cyc  = lat ? (cyc + LATENCY) : -1;
      exp_q.push_back(e);
      if (last) hist.delete();
   endtask

   task automatic send_sample(input int x, input bit last, input int gap_max, input bit lat);
      int  gap;
      bit  done;
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int i = 0; i < gap; i++) begin
         @(posedge clk); #1;
      end
      s_data  = 8'(x);
      s_last  = last;
      s_valid = 1'b1;
      done    = 1'b0;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(negedge clk);
         if (s_ready) begin
            model_accept(x, last, lat);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!done) chk("input_timeout", 0, 1);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic write_coef(input int addr, input int val);
      coef_addr  = 2'(addr);
      coef_wdata = 8'(val);
      coef_we    = 1'b1;
      @(posedge clk); #1;
      coef_we    = 1'b0;
   endtask

   task automatic set_coefs(input int h0, input int h1, input int h2, input int h3);
      write_coef(0, h0); write_coef(1, h1); write_coef(2, h2); write_coef(3, h3);
      model_h[0] = h0; model_h[1] = h1; model_h[2] = h2; model_h[3] = h3;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) done = 1'b1;
      end
      if (!done) chk("drain_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   // Downstream ready: always, random, or held low.
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (bp_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compare each output handshake with the scoreboard, and check
   // that a stalled beat stays valid and unchanged.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("hold_valid", int'(m_valid), 1);
            chk("hold_data", int'(m_data), hold_d);
            chk("hold_last", int'(m_last), int'(hold_l));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", int'(m_data), -99999);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", int'(m_data), e.data);
               chk("out_last", int'(m_last), int'(e.last));
               if (e.cyc >= 0) chk("out_latency", cyc, e.cyc);
            end
            hold_v = 1'b0;
         end else if (m_valid) begin
            hold_v = 1'b1;
            hold_d = int'(m_data);
            hold_l = m_last;
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   initial begin
      int xs[3];
      int p, se, we;
      logic signed [7:0] w8;
      bit got;
      int len;

      rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
      coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
      q_data = '0; q_valid = 1'b0; q_last = 1'b0; q_we = 1'b0; q_addr = '0; q_wdata = '0;
      one_r = 1'b1;
      model_h = '{1, 0, 0, 0};
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_tready", int'(s_ready), 1);
      chk("rst_mvalid", int'(m_valid), 0);
      chk("rst_mlast", int'(m_last), 0);
      chk("rst_mdata", int'(m_data), 0);
      chk("rst_busy", int'(busy), 0);
      @(posedge clk); #1;

      // Impulse with latency check
      bp_mode = 0;
      set_coefs(1, 2, 3, 4);
      send_sample(1, 1'b0, 0, 1'b1);
      for (int i = 0; i < 3; i++) send_sample(0, 1'b0, 0, 1'b1);
      send_sample(0, 1'b1, 0, 1'b1);
      wait_idle();

      // Ramp under random backpressure
      bp_mode = 1;
      set_coefs(1, 1, 1, 1);
      for (int i = 1; i <= 16; i++) send_sample(i, i == 16, 0, 1'b0);
      wait_idle();

      // Back-to-back packets: intake closed while draining
      bp_mode = 0;
      send_sample(5, 1'b0, 0, 1'b0);
      send_sample(5, 1'b1, 0, 1'b0);
      @(negedge clk);
      chk("drain_tready", int'(s_ready), 0);
      chk("drain_busy", int'(busy), 1);
      @(posedge clk); #1;
      send_sample(7, 1'b1, 0, 1'b0);
      wait_idle();

      // Coefficient write while busy is ignored
      send_sample(2, 1'b0, 0, 1'b0);
      chk("busy_run", int'(busy), 1);
      write_coef(0, 9);
      send_sample(3, 1'b1, 0, 1'b0);
      wait_idle();
      set_coefs(9, 0, 0, 0);
      send_sample(2, 1'b1, 0, 1'b0);
      wait_idle();
      // Write coinciding with an input handshake is ignored
      coef_addr = 2'd0; coef_wdata = 8'sd50; coef_we = 1'b1;
      send_sample(4, 1'b1, 0, 1'b0);
      coef_we = 1'b0;
      wait_idle();

      // Random packets, random coefficients, bubbles and backpressure
      for (int pk = 0; pk < 12; pk++) begin
         bp_mode = 0;
         set_coefs(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                   int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
         bp_mode = 1;
         len = int'($urandom_range(1, 7));
         for (int i = 0; i < len; i++) begin
            send_sample(int'($urandom_range(0, 255)) - 128, i == len - 1, 2, 1'b0);
         end
         wait_idle();
      end

      // Reset mid-packet with the skid buffer occupied
      bp_mode = 2;
      set_coefs(1, 1, 1, 1);
      send_sample(1, 1'b0, 0, 1'b0);
      send_sample(2, 1'b0, 0, 1'b0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("skid_full_tready", int'(s_ready), 0);
      chk("skid_full_mvalid", int'(m_valid), 1);
      rst = 1'b1;
      #1;
      chk("midrst_mvalid", int'(m_valid), 0);
      chk("midrst_busy", int'(busy), 0);
      exp_q.delete();
      hist.delete();
      model_h = '{1, 0, 0, 0};
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      bp_mode = 0;
      repeat (10) @(posedge clk);
      #1;
      send_sample(3, 1'b1, 0, 1'b0);
      wait_idle();

      // Narrowing: saturate vs wrap at 8-bit output
      q_addr = 2'd0; q_wdata = 8'sd127; q_we = 1'b1;
      @(posedge clk); #1;
      q_we = 1'b0;
      xs = '{127, -128, -1};
      foreach (xs[j]) begin
         p  = 127 * xs[j];
         se = (p > 127) ? 127 : ((p < -128) ? -128 : p);
         w8 = 8'(p);
         we = int'(w8);
         q_data = 8'(xs[j]); q_last = 1'b1; q_valid = 1'b1;
         @(negedge clk);
         chk("sat_tready", int'(sat_s_ready), 1);
         chk("wrap_tready", int'(wrap_s_ready), 1);
         @(posedge clk); #1;
         q_valid = 1'b0;
         got = 1'b0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (sat_m_valid) begin
               got = 1'b1;
               chk("sat_data", int'(sat_m_data), se);
               chk("sat_last", int'(sat_m_last), 1);
               chk("wrap_valid", int'(wrap_m_valid), 1);
               chk("wrap_data", int'(wrap_m_data), we);
               chk("wrap_last", int'(wrap_m_last), 1);
            end
         end
         if (!got) chk("sat_timeout", 0, 1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("sat_idle", int'(sat_busy), 0);
      chk("wrap_idle", int'(wrap_busy), 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_fir_filter_prog.md
AXIS_FIR_FILTER_PROG -- requirements
Module: axis_fir_filter_prog

Interface
REQ-001 Parameter NUM_TAPS, default 4: filter length, range 1..64.
REQ-002 Parameter TAP_WIDTH, default 8: signed coefficient width.
REQ-003 Parameter DATA_IN_WIDTH, default 8: signed input sample width.
REQ-004 Parameter DATA_OUT_WIDTH, default 18: signed output width.
REQ-005 Parameter SATURATE, default 1: 1 = saturate on output narrowing, 0 = wrap (truncate MSBs).
REQ-006 Derived constant ACC_WIDTH = DATA_IN_WIDTH+TAP_WIDTH+clog2(NUM_TAPS): full-precision accumulator width.
REQ-007 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  asynchronous active-high reset.
REQ-010 s_axis_tdata  in  DATA_IN_WIDTH  signed input sample.
REQ-011 s_axis_tvalid / s_axis_tlast  in  1 each  input valid; last sample of packet.
REQ-012 s_axis_tready  out  1  input ready.
REQ-013 m_axis_tdata  out  DATA_OUT_WIDTH  signed filtered sample.
REQ-014 m_axis_tvalid / m_axis_tlast  out  1 each  output valid; last output of packet.
REQ-015 m_axis_tready  in  1  downstream ready.
REQ-016 coef_wr_en  in  1  coefficient write strobe.
REQ-017 coef_addr  in  clog2(NUM_TAPS) (min 1)  tap index k.
REQ-018 coef_wdata  in  TAP_WIDTH  signed value for h[k].
REQ-019 busy  out  1  high while a packet is in flight.

Function
REQ-020 Output SHALL equal y[n] = sum over k of h[k]*x[n-k]; x[m] = 0 for samples before the packet's first sample; exactly one output per input; output tlast on the output of the input carrying tlast.
REQ-021 Latency SHALL be 3 cycles: input handshake in cycle c -> output m_axis_tvalid in cycle c+3 when no stall.
REQ-022 Pipeline: stage 1 shifts delay line on accepted input; stage 2 registers all NUM_TAPS products; stage 3 registers ACC_WIDTH sum then narrows; per-stage valid and last bits travel with data.
REQ-023 Narrowing: SATURATE=1 clamps to [-2^(DATA_OUT_WIDTH-1), 2^(DATA_OUT_WIDTH-1)-1]; SATURATE=0 keeps low DATA_OUT_WIDTH bits; DATA_OUT_WIDTH >= ACC_WIDTH sign-extends.
REQ-024 Output skid buffer (1 entry): stage-3 valid beat with m_axis_tready low and skid empty SHALL be captured; while skid full, m_axis_* driven from skid and whole pipeline frozen.
REQ-025 s_axis_tready SHALL be a registered/local signal = skid empty AND state != DRAIN; no combinational path from m_axis_tready to s_axis_tready.
REQ-026 Skid SHALL empty on the cycle m_axis_tready is high; no beat lost or duplicated under any ready/valid pattern.
REQ-027 m_axis_tvalid SHALL NOT drop, nor m_axis_tdata change, until handshake.
REQ-028 FSM states IDLE, RUN, DRAIN: IDLE->RUN on first accepted beat without tlast; IDLE or RUN->DRAIN on accepted beat with tlast; DRAIN->IDLE on output handshake with m_axis_tlast=1.
REQ-029 Entering IDLE SHALL clear the delay line to zero; busy = (state != IDLE).
REQ-030 coef_wr_en SHALL write h[coef_addr] at the next edge only when busy=0 and no input handshake in the same cycle; otherwise ignored; coef_addr >= NUM_TAPS ignored.
REQ-031 Single-sample packet (tlast on first beat) SHALL yield one output h[0]*x[0] with tlast.
REQ-032 Input bubbles (s_axis_tvalid low) SHALL not shift the delay line and SHALL propagate as invalid stages.

Reset
REQ-033 On rst: state IDLE, all valid bits, skid, delay line, products, accumulator = 0; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, s_axis_tready=1 from first edge after deassertion.
REQ-034 Coefficients on rst: h[0]=1, others 0 (identity).
REQ-035 Reset mid-packet SHALL discard all in-flight beats; no output emitted after deassertion until new input.

Structure
REQ-036 Package axis_fir_pkg SHALL hold the FSM state enum, LATENCY=3, and the ACC_WIDTH / saturation helper functions.
REQ-037 One sub-module axis_skid_buffer (parametrised data width, carries tlast) SHALL implement REQ-024..REQ-027.

Verification
REQ-038 Impulse: NUM_TAPS=4, h={1,2,3,4}, input {1,0,0,0,0} tlast on 5th -> outputs {1,2,3,4,0}, tlast on 5th, first valid 3 cycles after first handshake.
REQ-039 Backpressure: h={1,1,1,1}, ramp 1..16, m_axis_tready random 50% -> outputs {1,3,6,10,14,18,...,58} in order, none lost/duplicated.
REQ-040 Back-to-back packets {5,5} then {7}: outputs {5,10} tlast, then {7} tlast (history cleared, 2nd packet accepted only after DRAIN).
REQ-041 Coef write with busy=1 (h[0]:=9) ignored; same write with busy=0 takes effect: input {2} -> output {18}.
REQ-042 Saturation: DATA_OUT_WIDTH=8, SATURATE=1, h[0]=127, x=127 -> 127; x=-128 -> -128; SATURATE=0, x=127 -> 1 (16129 mod 256).
REQ-043 Reset asserted mid-packet with skid full -> m_axis_tvalid=0 immediately, busy=0, h reset to identity.
